// File: rtl/axis_frame_sink.sv
// axis_frame_sink
// ---------------
// Terminating AXI-stream sink for the consumer side of the async stream FIFO.
// Every incoming frame is measured (beat count, saturating), its tuser error
// marker is OR-accumulated, and one status record per frame is offered on a
// valid/ready status port.
//
// The sink never stores data. It applies backpressure only while a completed
// frame's status record is still waiting to be accepted downstream.
//
// Optional build feature:
//   AXIS_FRAME_SINK_CSUM_EN
//       Adds output status_csum, the XOR of tdata over every accepted beat of
//       the frame. It is registered alongside the other status fields.
//       Without the macro, tdata is unused.

module axis_frame_sink #(
    parameter int DATA_WIDTH = 8,
    parameter int LEN_WIDTH  = 16,
    parameter int MAX_LEN    = 1518
) (
    input  logic                  clk,
    input  logic                  async_rst_n,

    input  logic [DATA_WIDTH-1:0] input_axis_tdata,
    input  logic                  input_axis_tvalid,
    output logic                  input_axis_tready,
    input  logic                  input_axis_tlast,
    input  logic                  input_axis_tuser,

    output logic                  status_valid,
    input  logic                  status_ready,
    output logic [LEN_WIDTH-1:0]  status_len,
    output logic                  status_err,
    output logic                  status_too_long,
`ifdef AXIS_FRAME_SINK_CSUM_EN
    output logic [DATA_WIDTH-1:0] status_csum,
`endif
    output logic [31:0]           frame_count
);

    // Largest value the beat counter can hold; it sticks here instead of wrapping.
    localparam logic [LEN_WIDTH-1:0] CNT_MAX   = '1;
    localparam logic [LEN_WIDTH-1:0] MAX_LEN_L = LEN_WIDTH'(MAX_LEN);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RECV = 1'b1
    } state_t;

    state_t state_q;
    state_t state_d;

    // Handshake qualifiers shared by the FSM and the datapath.
    logic beat_accept;
    logic frame_done;
    logic status_take;

    // Per-frame accumulators.
    logic [LEN_WIDTH-1:0] cnt_q;
    logic [LEN_WIDTH-1:0] cnt_d;
    logic [LEN_WIDTH-1:0] cnt_next;
    logic                 err_acc_q;
    logic                 err_acc_d;
    logic                 err_next;

    // Registered status record and the frame counter.
    logic                 status_valid_q;
    logic                 status_valid_d;
    logic [LEN_WIDTH-1:0] status_len_q;
    logic [LEN_WIDTH-1:0] status_len_d;
    logic                 status_err_q;
    logic                 status_err_d;
    logic                 status_too_long_q;
    logic                 status_too_long_d;
    logic [31:0]          frame_count_q;
    logic [31:0]          frame_count_d;

`ifdef AXIS_FRAME_SINK_CSUM_EN
    logic [DATA_WIDTH-1:0] csum_acc_q;
    logic [DATA_WIDTH-1:0] csum_acc_d;
    logic [DATA_WIDTH-1:0] csum_next;
    logic [DATA_WIDTH-1:0] status_csum_q;
    logic [DATA_WIDTH-1:0] status_csum_d;
`else
    logic unused_tdata;
    assign unused_tdata = ^input_axis_tdata;
`endif

    // FSM state register; reset drops any partial frame back to IDLE.
    always_ff @(posedge clk or negedge async_rst_n) begin
        if (!async_rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: a non-last beat opens a frame, the last beat closes it.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (beat_accept && !input_axis_tlast) begin
                    state_d = RECV;
                end
            end
            RECV: begin
                if (beat_accept && input_axis_tlast) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // FSM outputs: ready only depends on the status port, never on tvalid/tlast.
    always_comb begin
        input_axis_tready = !status_valid_q || status_ready;
        beat_accept       = input_axis_tvalid && input_axis_tready;
        frame_done        = beat_accept && input_axis_tlast;
        status_take       = status_valid_q && status_ready;
    end

    // Accumulator values that include the beat currently being accepted.
    always_comb begin
        cnt_next = (cnt_q == CNT_MAX) ? cnt_q : (cnt_q + LEN_WIDTH'(1));
        err_next = err_acc_q || input_axis_tuser;
`ifdef AXIS_FRAME_SINK_CSUM_EN
        csum_next = csum_acc_q ^ input_axis_tdata;
`endif
    end

    // Datapath next state: load a record on completion, otherwise accumulate and retire.
    always_comb begin
        cnt_d             = cnt_q;
        err_acc_d         = err_acc_q;
        status_valid_d    = status_valid_q;
        status_len_d      = status_len_q;
        status_err_d      = status_err_q;
        status_too_long_d = status_too_long_q;
        frame_count_d     = frame_count_q;
`ifdef AXIS_FRAME_SINK_CSUM_EN
        csum_acc_d        = csum_acc_q;
        status_csum_d     = status_csum_q;
`endif

        if (frame_done) begin
            // A new record replaces any record accepted in this same cycle.
            status_valid_d    = 1'b1;
            status_len_d      = cnt_next;
            status_err_d      = err_next;
            status_too_long_d = (cnt_next > MAX_LEN_L);
            frame_count_d     = frame_count_q + 32'd1;
            cnt_d             = '0;
            err_acc_d         = 1'b0;
`ifdef AXIS_FRAME_SINK_CSUM_EN
            status_csum_d     = csum_next;
            csum_acc_d        = '0;
`endif
        end else begin
            if (beat_accept) begin
                cnt_d     = cnt_next;
                err_acc_d = err_next;
`ifdef AXIS_FRAME_SINK_CSUM_EN
                csum_acc_d = csum_next;
`endif
            end
            if (status_take) begin
                status_valid_d = 1'b0;
            end
        end
    end

    // Datapath registers; reset discards the partial frame and any pending record.
    always_ff @(posedge clk or negedge async_rst_n) begin
        if (!async_rst_n) begin
            cnt_q             <= '0;
            err_acc_q         <= 1'b0;
            status_valid_q    <= 1'b0;
            status_len_q      <= '0;
            status_err_q      <= 1'b0;
            status_too_long_q <= 1'b0;
            frame_count_q     <= 32'd0;
`ifdef AXIS_FRAME_SINK_CSUM_EN
            csum_acc_q        <= '0;
            status_csum_q     <= '0;
`endif
        end else begin
            cnt_q             <= cnt_d;
            err_acc_q         <= err_acc_d;
            status_valid_q    <= status_valid_d;
            status_len_q      <= status_len_d;
            status_err_q      <= status_err_d;
            status_too_long_q <= status_too_long_d;
            frame_count_q     <= frame_count_d;
`ifdef AXIS_FRAME_SINK_CSUM_EN
            csum_acc_q        <= csum_acc_d;
            status_csum_q     <= status_csum_d;
`endif
        end
    end

    assign status_valid    = status_valid_q;
    assign status_len      = status_len_q;
    assign status_err      = status_err_q;
    assign status_too_long = status_too_long_q;
    assign frame_count     = frame_count_q;
`ifdef AXIS_FRAME_SINK_CSUM_EN
    assign status_csum     = status_csum_q;
`endif

endmodule
